// File: rtl/alu_multdiv_pkg.sv
// Shared types and constants for the signed 32-bit multiply/divide unit.
package multdiv_pkg;

  localparam int          MULT_ITERS = 16;
  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  typedef enum logic [2:0] {ZERO, PLUS1, PLUS2, MINUS1, MINUS2} booth_op_e;

endpackage

// File: rtl/alu_multdiv_if.sv
// Execute-stage connection between pipeline control (master) and the mult/div unit (slave).
interface alu_multdiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/alu_multdiv_booth_recode.sv
// Radix-4 Booth recoder: three multiplier bits select 0, +-A or +-2A as a sign-extended addend.
module booth_recode
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        [2:0]       bits_i,
  input  logic signed [WIDTH-1:0] mcand_i,
  output booth_op_e               op_o,
  output logic signed [WIDTH+1:0] addend_o
);

  logic signed [WIDTH+1:0] a_ext;
  logic signed [WIDTH+1:0] a2_ext;

  // Two guard bits so that -2*INT_MIN is still representable.
  assign a_ext  = {{2{mcand_i[WIDTH-1]}}, mcand_i};
  assign a2_ext = a_ext <<< 1;

  always_comb begin
    op_o = ZERO;
    case (bits_i)
      3'b001, 3'b010: op_o = PLUS1;
      3'b011:         op_o = PLUS2;
      3'b100:         op_o = MINUS2;
      3'b101, 3'b110: op_o = MINUS1;
      default:        op_o = ZERO;
    endcase
  end

  always_comb begin
    addend_o = '0;
    case (op_o)
      PLUS1:   addend_o = a_ext;
      PLUS2:   addend_o = a2_ext;
      MINUS1:  addend_o = -a_ext;
      MINUS2:  addend_o = -a2_ext;
      default: addend_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_multdiv.sv
// Multicycle signed multiply (radix-4 Booth) / divide (non-restoring) unit with one-cycle ready pulse.
module alu_multdiv #(
  parameter int WIDTH      = 32,
  parameter int MULT_ITERS = WIDTH / 2,
  parameter int DIV_ITERS  = WIDTH
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_multdiv_if.slave bus
);
  import multdiv_pkg::*;

  localparam int CNT_W = $clog2(DIV_ITERS + 1);

  state_e                  state_q, state_d;
  logic        [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [WIDTH-1:0] mcand_q, mcand_d;
  logic      [2*WIDTH+1:0] prod_q, prod_d;
  logic signed [WIDTH+1:0] rem_q, rem_d;
  logic        [WIDTH-1:0] quo_q, quo_d;
  logic        [WIDTH-1:0] dvsr_q, dvsr_d;
  logic                    neg_q, neg_d;
  logic                    dz_q, dz_d;
  logic                    dovf_q, dovf_d;
  logic        [WIDTH-1:0] res_q, res_d;
  logic                    exc_q, exc_d;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : x;
  endfunction

  function automatic logic mul_overflow(input logic [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  function automatic logic [WIDTH-1:0] div_fixup(input logic [WIDTH-1:0] q,
                                                  input logic neg, input logic dz);
    if (dz) return '0;
    return neg ? WIDTH'(-q) : q;
  endfunction

  booth_op_e               booth_op;
  logic signed [WIDTH+1:0] addend;
  logic signed [WIDTH+1:0] acc_ext, acc_sum;
  logic      [2*WIDTH+1:0] prod_step;
  logic      [2*WIDTH-1:0] product;
  logic signed [WIDTH+1:0] rem_shift, rem_step;
  logic        [WIDTH-1:0] quo_step;

  booth_recode #(.WIDTH(WIDTH)) u_booth (
    .bits_i   (prod_q[2:0]),
    .mcand_i  (mcand_q),
    .op_o     (booth_op),
    .addend_o (addend)
  );

  // Register layout {acc[WIDTH:0], multiplier, guard}; add into acc then arithmetic shift by 2.
  assign acc_ext   = {prod_q[2*WIDTH+1], prod_q[2*WIDTH+1:WIDTH+1]};
  assign acc_sum   = (booth_op == ZERO) ? acc_ext : acc_ext + addend;
  assign prod_step = {acc_sum[WIDTH+1], acc_sum, prod_q[WIDTH:2]};
  assign product   = prod_q[2*WIDTH:1];

  assign rem_shift = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
  assign rem_step  = rem_q[WIDTH+1] ? rem_shift + {2'b00, dvsr_q} : rem_shift - {2'b00, dvsr_q};
  assign quo_step  = {quo_q[WIDTH-2:0], ~rem_step[WIDTH+1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    dovf_d  = dovf_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      state_d = bus.ctrl_MULT ? MULT : DIV;
      cnt_d   = '0;
      mcand_d = bus.data_operandA;
      prod_d  = {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
      rem_d   = '0;
      quo_d   = magnitude(bus.data_operandA);
      dvsr_d  = magnitude(bus.data_operandB);
      neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      dz_d    = (bus.data_operandB == '0);
      dovf_d  = (bus.data_operandB == '0) ||
                ((bus.data_operandA == INT_MIN) && (bus.data_operandB == '1));
    end else begin
      case (state_q)
        MULT: begin
          if (cnt_q == CNT_W'(MULT_ITERS)) begin
            state_d = DONE;
            res_d   = product[WIDTH-1:0];
            exc_d   = mul_overflow(product);
          end else begin
            prod_d = prod_step;
            cnt_d  = cnt_q + 1'b1;
          end
        end
        DIV: begin
          if (cnt_q == CNT_W'(DIV_ITERS)) begin
            state_d = DONE;
            res_d   = div_fixup(quo_q, neg_q, dz_q);
            exc_d   = dovf_q;
          end else begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      dovf_q  <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      dovf_q  <= dovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.data_result    = res_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = (state_q == DONE);
  assign bus.busy           = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_alu_multdiv.sv
// Scoreboard bench for alu_multdiv: stimulus pushes reference results with their due cycle, a monitor pops on ready.
module tb_alu_multdiv;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_multdiv_if #(.WIDTH(32)) bus ();

  alu_multdiv dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(input bit mult, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint p;
    int     q;
    r.due = 0;
    if (mult) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      r.res = p[31:0];
      r.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == 32'd0) begin
      r.res = 32'd0;
      r.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r.res = 32'h8000_0000;
      r.exc = 1'b1;
    end else begin
      q     = $signed(a) / $signed(b);
      r.res = q;
      r.exc = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Pulses a start for one cycle; operands are scrambled right after the sampling edge.
  task automatic start_op(input bit mult, input logic [31:0] a, input logic [31:0] b,
                          input bit track, output int k);
    exp_t e;
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = mult;
    bus.ctrl_DIV      = !mult;
    @(posedge clock);
    #1;
    k = cyc;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    if (track) begin
      e     = model(mult, a, b);
      e.due = k + (mult ? 17 : 33);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still pending at cycle %0d", sb.size(), cyc);
      sb.delete();
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [5];
    int          s;
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1: begin s = int'($urandom_range(0, 200)) - 100; return s; end
      2:       return specials[$urandom_range(0, 4)];
      default: return $urandom >> $urandom_range(1, 30);
    endcase
  endfunction

  always @(negedge clock) begin
    if (bus.data_resultRDY === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rdy: ready at cycle %0d with result %h, expected no ready", cyc, bus.data_result);
      end else begin
        mon_e = sb.pop_front();
        if (bus.data_result !== mon_e.res || bus.data_exception !== mon_e.exc || cyc != mon_e.due) begin
          n_fail++;
          $display("FAIL result: got %h exc=%b at cycle %0d, expected %h exc=%b at cycle %0d",
                   bus.data_result, bus.data_exception, cyc, mon_e.res, mon_e.exc, mon_e.due);
        end
      end
    end
  end

  initial begin
    int k;
    int hi;
    bit mult;
    logic [31:0] a, b;

    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rdy", 32'(bus.data_resultRDY), 32'd0);
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exc", 32'(bus.data_exception), 32'd0);
    reset_n = 1'b1;

    // 7 * -3 with busy window observed cycle by cycle
    start_op(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1, k);
    hi = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        @(posedge clock);
        #1;
      end
      if (bus.busy) hi++;
    end
    @(posedge clock);
    #1;
    check("busy_cycles", 32'(hi), 32'd17);
    check("busy_low_in_done", 32'(bus.busy), 32'd0);
    drain();

    start_op(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1, k); drain();
    start_op(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b1, k);         drain();
    start_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, k);         drain();
    start_op(1'b0, 32'd100, 32'd7, 1'b1, k);               drain();
    start_op(1'b0, 32'd5, 32'd0, 1'b1, k);                 drain();
    start_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, k); drain();
    start_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, k); drain();

    // Divide aborted by a multiply ten edges later
    start_op(1'b0, 32'd100, 32'd7, 1'b0, k);
    repeat (9) @(posedge clock);
    start_op(1'b1, 32'd6, 32'd7, 1'b1, k);
    drain();
    repeat (20) @(posedge clock);

    for (int n = 0; n < 40; n++) begin
      mult = 1'($urandom_range(0, 1));
      a    = rand_operand();
      b    = rand_operand();
      start_op(mult, a, b, 1'b1, k);
      drain();
    end

    // Reset at edge k+5 of a multiply
    start_op(1'b1, 32'd1234, 32'd5678, 1'b0, k);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_result", bus.data_result, 32'd0);
    check("abort_exc", 32'(bus.data_exception), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_multdiv.md
Name: alu_multdiv

Overview:
- Multicycle signed 32-bit multiply/divide unit in the execute stage, beside the bitwise ALU slices (AND/OR/add/shift).
- Takes the same operandA/operandB as the ALU.
- Produces a registered result plus overflow/exception flag and a one-cycle ready pulse.
- Pipeline control stalls on `busy` and writes back on `data_resultRDY`.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.
- MULT_ITERS, WIDTH/2, radix-4 Booth iterations (16).
- DIV_ITERS, WIDTH, non-restoring divide iterations (32).

Ports:
- clock  in  1  single clock, rising-edge.
- reset_n  in  1  reset, synchronous, active-low.
- data_operandA  in  32  multiplicand / dividend.
- data_operandB  in  32  multiplier / divisor.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_result  out  32  product low word / quotient.
- data_exception  out  1  multiply overflow, divide-by-zero or divide overflow.
- data_resultRDY  out  1  result valid, exactly one cycle.
- busy  out  1  operation in progress.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset:
  - On a clock edge with reset_n=0, go to IDLE and clear all outputs and internal registers to 0.
  - This aborts any operation in flight; no RDY pulse follows.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - At edge k, ctrl_MULT=1 or ctrl_DIV=1 latches both operands and sets iteration count to 0.
  - Next state is MULT or DIV.
  - If both are high, ctrl_MULT wins.
  - Starting is allowed from any state: a start while in MULT/DIV/DONE aborts the current operation, suppresses its RDY, and restarts.
- MULT:
  - One radix-4 Booth step per cycle over a 66-bit {acc, multiplier, guard} register.
  - After MULT_ITERS steps, at edge k+16, go to DONE.
- DIV:
  - One non-restoring step per cycle on operand magnitudes.
  - Signs are fixed up after the last step.
  - After DIV_ITERS steps, at edge k+32, go to DONE.
- DONE:
  - On entry (edge k+17 for multiply, k+33 for divide), register data_result and data_exception and assert data_resultRDY.
  - RDY is high for exactly one cycle; next state is IDLE.
- Output hold:
  - data_result and data_exception keep their values until the next DONE or reset.
  - They are not cleared by a new start.
- busy: high while in MULT or DIV; low in IDLE and DONE.
- Multiply:
  - data_result = low 32 bits of the signed 64-bit product.
  - data_exception = 1 iff product bits [63:31] are not all equal.
- Divide:
  - Signed quotient, truncated toward zero; remainder discarded.
  - B==0: result 0, exception 1.
  - A=0x80000000 with B=0xFFFFFFFF: result 0x80000000, exception 1.
  - Latency is the same for all operands, including these special cases.
- Operand inputs may change after edge k without effect.
- ctrl pulses held high for several cycles restart the operation every cycle; the control unit issues single-cycle pulses.

Decomposition:
- Package multdiv_pkg holds:
  - state enum {IDLE, MULT, DIV, DONE};
  - constants MULT_ITERS, DIV_ITERS, INT_MIN=32'h80000000;
  - Booth op encoding {ZERO, PLUS1, PLUS2, MINUS1, MINUS2}.
- One sub-module, booth_recode: combinational; maps 3 multiplier bits to a Booth op and the selected ±A/±2A addend.
- The controller, counter and datapath registers stay in alu_multdiv.

Test Plan:
- Multiply A=7, B=-3 (0xFFFFFFFD) pulsed at edge k:
  - busy=1 from k through k+16;
  - at k+17: result=0xFFFFFFEB, exception=0, RDY=1 for one cycle.
- Multiply 0x00010000 × 0x00010000 → result=0x00000000, exception=1.
- Multiply 0x7FFFFFFF × 1 → result=0x7FFFFFFF, exception=0.
- Divide -7 (0xFFFFFFF9) / 2 at k:
  - at k+33: result=0xFFFFFFFD, exception=0;
  - also 100/7 → 14.
- Divide 5/0 → result=0, exception=1.
- Divide 0x80000000 / 0xFFFFFFFF → result=0x80000000, exception=1.
- Restart: ctrl_DIV 100/7 at k, then ctrl_MULT 6×7 at k+10:
  - no RDY near k+33;
  - RDY at k+27 with result=42 (0x2A).
- Reset: reset_n=0 at edge k+5 of a multiply:
  - after that edge: busy=0, result=0, exception=0;
  - no RDY in the following 40 cycles.
